// File: rtl/ram_pipelined.sv
// Simple dual-port RAM with per-byte write enables, write-first bypass, a 1- or 2-stage
// registered read path with a valid strobe, and a clear sweep that runs on reset or on request.
module ram_pipelined #(
    parameter int                        ADDRESS_WIDTH = 10,
    parameter int                        DATA_WIDTH    = 16,
    parameter int                        READ_LATENCY  = 1,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    output logic                         busy,
    input  logic                         WRITE_EN,
    input  logic [ADDRESS_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic                         READ_EN,
    input  logic [ADDRESS_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_valid
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                     clr_we, wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0]    rd_word;

    logic [DATA_WIDTH-1:0]                  mem [DEPTH];
    logic [READ_LATENCY:1]                  vld_q;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0]  dat_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign clr_we  = (state_q == CLEAR) && !rst;
    assign wr_fire = (state_q == IDLE) && WRITE_EN && !rst;
    assign rd_fire = (state_q == IDLE) && READ_EN && !rst;

    // Write-first: a same-cycle write to the read address overlays its enabled bytes.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_fire && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) rd_word[8*b +: 8] = din[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end else if (wr_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[wr_addr][8*b +: 8] <= din[8*b +: 8];
            end
        end
    end

    // Data stages only load on a valid word so dout holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[1] <= rd_fire;
            if (rd_fire) dat_q[1] <= rd_word;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign dout       = dat_q[READ_LATENCY];
    assign dout_valid = vld_q[READ_LATENCY];
endmodule
